alarm_time_setter: RTL
======================

# alarm_time_setter

User-side front end for the `alarm_clock` load interface. It turns four debounced push-button levels into edited BCD hour/minute digits and single-cycle `LD_time`/`LD_alarm` strobes, which drive the clock's `H_in*`/`M_in*`/`LD_*` inputs directly. Editing starts from the clock's current time or from the last committed alarm. An inactivity timeout abandons an edit without loading anything.

## Interface
- `REPEAT_DELAY`, default 50_000_000: cycles an increment button must be held before auto-repeat starts.
- `REPEAT_PERIOD`, default 10_000_000: cycles between auto-repeat increments.
- `TIMEOUT_CYCLES`, default 1_000_000_000: idle cycles in an edit state before it is abandoned.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `btn_mode`, `btn_set`, `btn_inc_h`, `btn_inc_m`  in  1 each  debounced, synchronized button levels.
- `H_cur1`  in  2, `H_cur0`  in  4, `M_cur1`  in  3, `M_cur0`  in  4  current clock time, BCD; tie to `H_out*`/`M_out*`.
- `H_in1`  out  2, `H_in0`  out  4, `M_in1`  out  3, `M_in0`  out  4  edited digits, BCD.
- `LD_time`  out  1  one-cycle strobe that loads the clock time.
- `LD_alarm`  out  1  one-cycle strobe that loads the alarm time.
- `edit_mode`  out  2  current mode: 0 idle, 1 editing time, 2 editing alarm.

## Operation
- Rising edge of each button = level high now and low in the previous cycle (one register stage per button).
- FSM states and transitions:
  - IDLE, on `mode` edge: capture `*_cur` into the digit registers, go to EDIT_TIME.
  - EDIT_TIME, on `mode` edge: load the digit registers from the alarm shadow, go to EDIT_ALARM.
  - EDIT_ALARM, on `mode` edge: return to IDLE with no strobe (cancel).
  - EDIT_TIME, on `set` edge: pulse `LD_time`, go to IDLE.
  - EDIT_ALARM, on `set` edge: pulse `LD_alarm`, copy the digits into the alarm shadow, go to IDLE.
- In an edit state, an `inc_h` edge advances hours 00→01→…→23→00.
  - Increment `H_in0`. At 9, roll `H_in0` to 0 and increment `H_in1`.
  - At 23, wrap to 00.
- In an edit state, an `inc_m` edge advances minutes 00→…→59→00.
  - Minute wrap does not carry into hours.
- Auto-repeat for each increment button, with its own counter:
  - The counter starts at the edge.
  - After `REPEAT_DELAY` cycles of continuous hold, one increment fires.
  - Another increment fires every `REPEAT_PERIOD` cycles after that.
  - Release clears the counter.
- Priority within one cycle: `mode` > `set` > increments. `inc_h` and `inc_m` may apply together. Increments are ignored in IDLE.
- Timeout counter:
  - Clears on any button edge or auto-repeat increment, and on entry to an edit state.
  - At `TIMEOUT_CYCLES` it returns to IDLE with no strobe.
- Digit outputs hold their value in IDLE. They change only on capture, alarm-shadow load, or increment.
- The alarm shadow changes only on an alarm commit.

## Timing
- Reset values: all digits 0, `LD_time`=0, `LD_alarm`=0, `edit_mode`=0, alarm shadow 00:00, all counters 0, FSM in IDLE, button history registers 0.
- A button held high through reset produces no edge afterwards.
- Button latency: a level rising before clock edge N is detected at edge N. State, digits and strobe registers update at edge N+1 and are visible after it.
- `LD_*` is high for exactly one cycle. The digits are stable in that cycle and in the following cycle.
- `LD_time` and `LD_alarm` are never high together.
- Capture of `*_cur` happens at the edge that enters EDIT_TIME. A clock tick one cycle later is not reflected.
- Invalid BCD on `*_cur` is passed through as-is. Increments from an invalid digit wrap on the next roll.
- Reset in the middle of an edit goes to IDLE with no strobe. The alarm shadow is cleared.

## Structure
- Shared package `alarm_clock_pkg`:
  - FSM state encoding (IDLE, EDIT_TIME, EDIT_ALARM).
  - BCD limit constants: hour max 23, minute tens max 5, digit max 9.
  - Widths of the digit fields.
- Sub-module `btn_repeat`, instantiated twice (hours, minutes):
  - Performs edge detection and the auto-repeat counter.
  - Emits a one-cycle `step` pulse.
  - Takes `REPEAT_DELAY` and `REPEAT_PERIOD` as parameters.

## Test plan
Parameters for the bench: `REPEAT_DELAY`=8, `REPEAT_PERIOD`=4, `TIMEOUT_CYCLES`=100.
- **Load time.** Current time 04:59 → press `mode`, press `inc_m`, press `set`.
  - Expect: digits 04:00.
  - Expect: `LD_time` high for one cycle.
  - Expect: `edit_mode` returns to 0.
- **Hour wrap, alarm commit.** Press `mode` twice, 23 `inc_h` edges, press `set`.
  - Expect: hours 00→…→23 with a correct tens roll at 09→10 and 19→20.
  - Expect: one more `inc_h` edge wraps to 00.
  - Expect: `LD_alarm` pulses once on `set`.
  - Expect: re-entering EDIT_ALARM shows the committed value.
- **Cancel.** Press `mode` three times after editing.
  - Expect: no strobe.
  - Expect: the alarm shadow is unchanged.
- **Auto-repeat.** Hold `inc_m` for 20 cycles from 58.
  - Expect: 59 at the edge.
  - Expect: 00 after 8 cycles, then 01 and 02 at 4-cycle spacing.
  - Expect: no change after release.
- **Timeout.** Enter EDIT_TIME and stay idle for 100 cycles.
  - Expect: `edit_mode`=0 with no `LD_time`.
- **Simultaneous events and reset.**
  - `mode` and `set` rise in the same cycle in EDIT_TIME → EDIT_ALARM, no strobe.
  - `reset` mid-edit → all outputs 0, shadow 00:00.

Source files
------------

// File: rtl/alarm_clock_pkg.sv
// Shared definitions for the alarm clock front end: edit FSM encoding,
// BCD field widths and limits, and the hour/minute increment helpers.
package alarm_clock_pkg;

    localparam int H1_W = 2;
    localparam int H0_W = 4;
    localparam int M1_W = 3;
    localparam int M0_W = 4;

    localparam int HOUR_MAX      = 23;
    localparam int MIN_TENS_LIM  = 5;
    localparam int DIGIT_LIM     = 9;

    localparam logic [H1_W-1:0] HOUR_TENS_MAX = H1_W'(HOUR_MAX / 10);
    localparam logic [H0_W-1:0] HOUR_ONES_MAX = H0_W'(HOUR_MAX % 10);
    localparam logic [M1_W-1:0] MIN_TENS_MAX  = M1_W'(MIN_TENS_LIM);
    localparam logic [H0_W-1:0] DIGIT_MAX     = H0_W'(DIGIT_LIM);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_EDIT_TIME  = 2'd1,
        ST_EDIT_ALARM = 2'd2
    } edit_state_e;

    typedef struct packed {
        logic [H1_W-1:0] h1;
        logic [H0_W-1:0] h0;
        logic [M1_W-1:0] m1;
        logic [M0_W-1:0] m0;
    } bcd_time_t;

    // Invalid digits are not clamped; they count up and wrap at their field width.
    function automatic bcd_time_t inc_hours(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.h1 == HOUR_TENS_MAX && t.h0 == HOUR_ONES_MAX) begin
            r.h1 = '0;
            r.h0 = '0;
        end else if (t.h0 == DIGIT_MAX) begin
            r.h0 = '0;
            r.h1 = t.h1 + H1_W'(1);
        end else begin
            r.h0 = t.h0 + H0_W'(1);
        end
        return r;
    endfunction

    function automatic bcd_time_t inc_minutes(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.m0 == DIGIT_MAX) begin
            r.m0 = '0;
            r.m1 = (t.m1 == MIN_TENS_MAX) ? '0 : t.m1 + M1_W'(1);
        end else begin
            r.m0 = t.m0 + M0_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_time_setter_btn_repeat.sv
// Rising-edge detector plus hold-to-repeat counter for one increment button;
// emits a registered one-cycle step on the edge and on every repeat.
module btn_repeat #(
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic step
);

    logic        prev_q, prev_d;
    logic        armed_q, armed_d;
    logic        rep_q, rep_d;
    logic        step_q, step_d;
    logic [31:0] cnt_q, cnt_d;
    logic        rise;

    // armed_q masks the first cycle after reset so a held button is not an edge.
    assign rise = btn & ~prev_q & armed_q;

    always_comb begin
        prev_d  = btn;
        armed_d = 1'b1;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        step_d  = 1'b0;
        if (!btn) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (rise) begin
            cnt_d  = 32'd1;
            rep_d  = 1'b0;
            step_d = 1'b1;
        end else if (cnt_q != '0) begin
            if ((!rep_q && cnt_q == REPEAT_DELAY) || (rep_q && cnt_q == REPEAT_PERIOD)) begin
                step_d = 1'b1;
                rep_d  = 1'b1;
                cnt_d  = 32'd1;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            rep_q   <= 1'b0;
            step_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            prev_q  <= prev_d;
            armed_q <= armed_d;
            rep_q   <= rep_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/alarm_time_setter.sv
// Button-driven editor for the alarm clock's time/alarm load interface:
// captures or recalls BCD digits, edits them, and issues LD_time/LD_alarm strobes.
module alarm_time_setter #(
    parameter int unsigned REPEAT_DELAY   = 50_000_000,
    parameter int unsigned REPEAT_PERIOD  = 10_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       btn_inc_h,
    input  logic       btn_inc_m,
    input  logic [1:0] H_cur1,
    input  logic [3:0] H_cur0,
    input  logic [2:0] M_cur1,
    input  logic [3:0] M_cur0,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [2:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic [1:0] edit_mode
);
    import alarm_clock_pkg::*;

    logic        mode_prev_q, mode_prev_d, set_prev_q, set_prev_d;
    logic        armed_q, armed_d;
    logic        mode_e_q, mode_e_d, set_e_q, set_e_d;
    logic        step_h, step_m;
    edit_state_e state_q, state_d;
    bcd_time_t   time_q, time_d, shadow_q, shadow_d, cur_time;
    logic        ld_time_q, ld_time_d, ld_alarm_q, ld_alarm_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        any_evt, in_edit, timeout, strobe_busy;

    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_rep_h (
        .clk(clk), .reset(reset), .btn(btn_inc_h), .step(step_h)
    );

    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_rep_m (
        .clk(clk), .reset(reset), .btn(btn_inc_m), .step(step_m)
    );

    assign cur_time = {H_cur1, H_cur0, M_cur1, M_cur0};

    always_comb begin
        mode_prev_d = btn_mode;
        set_prev_d  = btn_set;
        armed_d     = 1'b1;
        mode_e_d    = btn_mode & ~mode_prev_q & armed_q;
        set_e_d     = btn_set & ~set_prev_q & armed_q;
    end

    assign any_evt     = mode_e_q | set_e_q | step_h | step_m;
    assign in_edit     = (state_q != ST_IDLE);
    assign timeout     = in_edit && !any_evt && (to_cnt_q == TIMEOUT_CYCLES - 1);
    // A capture right after a strobe would disturb the digits the clock is loading.
    assign strobe_busy = ld_time_q | ld_alarm_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (mode_e_q && !strobe_busy) state_d = ST_EDIT_TIME;
            end
            ST_EDIT_TIME: begin
                if (mode_e_q)                state_d = ST_EDIT_ALARM;
                else if (set_e_q || timeout) state_d = ST_IDLE;
            end
            ST_EDIT_ALARM: begin
                if (mode_e_q || set_e_q || timeout) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        time_d     = time_q;
        shadow_d   = shadow_q;
        ld_time_d  = 1'b0;
        ld_alarm_d = 1'b0;
        to_cnt_d   = (!in_edit || any_evt) ? '0 : to_cnt_q + 32'd1;
        unique case (state_q)
            ST_IDLE: begin
                if (mode_e_q && !strobe_busy) time_d = cur_time;
            end
            ST_EDIT_TIME: begin
                if (mode_e_q) begin
                    time_d = shadow_q;
                end else if (set_e_q) begin
                    ld_time_d = 1'b1;
                end else begin
                    if (step_h) time_d = inc_hours(time_d);
                    if (step_m) time_d = inc_minutes(time_d);
                end
            end
            ST_EDIT_ALARM: begin
                if (!mode_e_q && set_e_q) begin
                    ld_alarm_d = 1'b1;
                    shadow_d   = time_q;
                end else if (!mode_e_q) begin
                    if (step_h) time_d = inc_hours(time_d);
                    if (step_m) time_d = inc_minutes(time_d);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_prev_q <= 1'b0;
            set_prev_q  <= 1'b0;
            armed_q     <= 1'b0;
            mode_e_q    <= 1'b0;
            set_e_q     <= 1'b0;
            time_q      <= '0;
            shadow_q    <= '0;
            ld_time_q   <= 1'b0;
            ld_alarm_q  <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            mode_prev_q <= mode_prev_d;
            set_prev_q  <= set_prev_d;
            armed_q     <= armed_d;
            mode_e_q    <= mode_e_d;
            set_e_q     <= set_e_d;
            time_q      <= time_d;
            shadow_q    <= shadow_d;
            ld_time_q   <= ld_time_d;
            ld_alarm_q  <= ld_alarm_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign H_in1     = time_q.h1;
    assign H_in0     = time_q.h0;
    assign M_in1     = time_q.m1;
    assign M_in0     = time_q.m0;
    assign LD_time   = ld_time_q;
    assign LD_alarm  = ld_alarm_q;
    assign edit_mode = state_q;

endmodule
